// File: rtl/axi_dma_w_beat_gen.sv
// AXI W-channel beat generator: turns a held write descriptor into W beats with
// first/last byte strobes, popping one realigned buffer word per beat.
module axi_dma_w_beat_gen #(
  parameter int unsigned DataWidth = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [$clog2(DataWidth/8)-1:0]       desc_offset_i,
  input  logic [$clog2(DataWidth/8)-1:0]       desc_tailer_i,
  input  logic [7:0]                           desc_num_beats_i,
  input  logic                                 desc_is_single_i,
  input  logic                                 desc_valid_i,
  output logic                                 desc_ready_o,
  input  logic [DataWidth-1:0]                 buf_data_i,
  input  logic                                 buf_valid_i,
  output logic                                 buf_ready_o,
  output logic [DataWidth-1:0]                 w_data_o,
  output logic [DataWidth/8-1:0]               w_strb_o,
  output logic                                 w_last_o,
  output logic                                 w_valid_o,
  input  logic                                 w_ready_i,
  output logic                                 burst_done_o
);

  localparam int unsigned StrbWidth   = DataWidth / 8;
  localparam int unsigned OffsetWidth = $clog2(StrbWidth);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e                 state_q, state_d;
  logic [OffsetWidth-1:0] offset_q, offset_d;
  logic [OffsetWidth-1:0] tailer_q, tailer_d;
  logic [7:0]             num_beats_q, num_beats_d;
  logic                   is_single_q, is_single_d;
  logic [7:0]             beat_cnt_q, beat_cnt_d;

  logic                 in_burst;
  logic                 last;
  logic                 beat_hs;
  logic                 desc_hs;
  logic [StrbWidth-1:0] first_mask;
  logic [StrbWidth-1:0] last_mask;
  logic [StrbWidth-1:0] strb;

  always_comb begin
    // Outputs are forced low during reset, so an aborted burst never shows last/done.
    in_burst     = (state_q == StBurst) && !rst_i;
    last         = (beat_cnt_q == num_beats_q) || is_single_q;
    w_valid_o    = in_burst && buf_valid_i;
    buf_ready_o  = in_burst && w_ready_i;
    beat_hs      = w_valid_o && w_ready_i;
    w_last_o     = in_burst && last;
    burst_done_o = beat_hs && last;
    desc_ready_o = !rst_i && ((state_q == StIdle) || burst_done_o);
    desc_hs      = desc_valid_i && desc_ready_o;
    w_data_o     = buf_data_i;

    first_mask = {StrbWidth{1'b1}} << offset_q;
    last_mask  = (tailer_q == '0) ? {StrbWidth{1'b1}} : ~({StrbWidth{1'b1}} << tailer_q);
    strb       = {StrbWidth{1'b1}};
    if (beat_cnt_q == 8'd0) strb = strb & first_mask;
    if (last)               strb = strb & last_mask;
    w_strb_o   = in_burst ? strb : '0;
  end

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    tailer_d    = tailer_q;
    num_beats_d = num_beats_q;
    is_single_d = is_single_q;
    beat_cnt_d  = beat_cnt_q;

    if (beat_hs) beat_cnt_d = beat_cnt_q + 8'd1;

    // A descriptor taken on the last beat reloads in place for a bubble-free chain.
    if (desc_hs) begin
      state_d     = StBurst;
      offset_d    = desc_offset_i;
      tailer_d    = desc_tailer_i;
      num_beats_d = desc_num_beats_i;
      is_single_d = desc_is_single_i;
      beat_cnt_d  = 8'd0;
    end else if (burst_done_o) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      offset_q    <= '0;
      tailer_q    <= '0;
      num_beats_q <= 8'd0;
      is_single_q <= 1'b0;
      beat_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      tailer_q    <= tailer_d;
      num_beats_q <= num_beats_d;
      is_single_q <= is_single_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_dma_w_beat_gen.sv
// Bench for axi_dma_w_beat_gen: descriptor table plus hand-written stall, chaining
// and reset sequences; W beats are checked against a queue of expected beats.
module tb_axi_dma_w_beat_gen;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  desc_offset_i;
  logic [2:0]  desc_tailer_i;
  logic [7:0]  desc_num_beats_i;
  logic        desc_is_single_i;
  logic        desc_valid_i;
  logic        desc_ready_o;
  logic [63:0] buf_data_i;
  logic        buf_valid_i;
  logic        buf_ready_o;
  logic [63:0] w_data_o;
  logic [7:0]  w_strb_o;
  logic        w_last_o;
  logic        w_valid_o;
  logic        w_ready_i;
  logic        burst_done_o;

  axi_dma_w_beat_gen #(.DataWidth(64)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .desc_offset_i    (desc_offset_i),
    .desc_tailer_i    (desc_tailer_i),
    .desc_num_beats_i (desc_num_beats_i),
    .desc_is_single_i (desc_is_single_i),
    .desc_valid_i     (desc_valid_i),
    .desc_ready_o     (desc_ready_o),
    .buf_data_i       (buf_data_i),
    .buf_valid_i      (buf_valid_i),
    .buf_ready_o      (buf_ready_o),
    .w_data_o         (w_data_o),
    .w_strb_o         (w_strb_o),
    .w_last_o         (w_last_o),
    .w_valid_o        (w_valid_o),
    .w_ready_i        (w_ready_i),
    .burst_done_o     (burst_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0] off;
    logic [2:0] tail;
    logic [7:0] nb;
    logic       single;
    logic [7:0] s_first;  // strobe of beat 0 (both masks for a one-beat burst)
    logic [7:0] s_last;   // strobe of the final beat of a multi-beat burst
  } vec_t;

  typedef struct {
    logic [7:0] strb;
    logic       last;
  } beat_t;

  vec_t  vecs[6];
  beat_t exp_q[$];
  beat_t e;
  int    total = 0;
  int    bad   = 0;

  // Buffer model: a new word is presented after every pop.
  logic [15:0] buf_word = 16'd0;
  logic [15:0] exp_word = 16'd0;
  assign buf_data_i = {4{buf_word}};
  always @(posedge clk_i) if (buf_valid_i && buf_ready_o) buf_word <= buf_word + 16'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every W handshake pops one expected beat.
  always @(negedge clk_i) begin
    if (w_valid_o && w_ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got strb %0h expected no beat", w_strb_o);
      end else begin
        e = exp_q.pop_front();
        chk("beat_strb", {56'd0, w_strb_o}, {56'd0, e.strb});
        chk("beat_last", {63'd0, w_last_o}, {63'd0, e.last});
        chk("beat_done", {63'd0, burst_done_o}, {63'd0, e.last});
        chk("beat_data", w_data_o, {4{exp_word}});
        chk("beat_pop", {63'd0, buf_ready_o}, 64'd1);
      end
      exp_word = exp_word + 16'd1;
    end else if (burst_done_o) begin
      chk("done_without_beat", {63'd0, burst_done_o}, 64'd0);
    end
  end

  task automatic push_beats(input vec_t v);
    int n;
    beat_t b;
    n = v.single ? 0 : int'(v.nb);
    for (int k = 0; k <= n; k++) begin
      b.strb = (k == 0) ? v.s_first : ((k == n) ? v.s_last : 8'hFF);
      b.last = (k == n);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_desc(input vec_t v);
    desc_offset_i    = v.off;
    desc_tailer_i    = v.tail;
    desc_num_beats_i = v.nb;
    desc_is_single_i = v.single;
    desc_valid_i     = 1'b1;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 2000) begin
      @(negedge clk_i);
      i++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk_i); #1;
    drive_desc(v);
    @(negedge clk_i);
    chk("desc_ready_idle", {63'd0, desc_ready_o}, 64'd1);
    chk("no_early_valid", {63'd0, w_valid_o}, 64'd0);
    push_beats(v);
    @(posedge clk_i); #1;
    desc_valid_i = 1'b0;
    drain();
  endtask

  vec_t va, vb;

  initial begin
    vecs[0] = '{off: 3'd3, tail: 3'd5, nb: 8'd2,   single: 1'b0, s_first: 8'hF8, s_last: 8'h1F};
    vecs[1] = '{off: 3'd2, tail: 3'd6, nb: 8'd0,   single: 1'b1, s_first: 8'h3C, s_last: 8'h3C};
    vecs[2] = '{off: 3'd0, tail: 3'd0, nb: 8'd0,   single: 1'b1, s_first: 8'hFF, s_last: 8'hFF};
    vecs[3] = '{off: 3'd0, tail: 3'd0, nb: 8'd255, single: 1'b0, s_first: 8'hFF, s_last: 8'hFF};
    vecs[4] = '{off: 3'd7, tail: 3'd1, nb: 8'd1,   single: 1'b0, s_first: 8'h80, s_last: 8'h01};
    vecs[5] = '{off: 3'd1, tail: 3'd0, nb: 8'd3,   single: 1'b0, s_first: 8'hFE, s_last: 8'hFF};

    rst_i = 1'b1;
    desc_valid_i = 1'b1;
    desc_offset_i = 3'd3;
    desc_tailer_i = 3'd5;
    desc_num_beats_i = 8'd2;
    desc_is_single_i = 1'b0;
    buf_valid_i = 1'b1;
    w_ready_i = 1'b1;

    // Reset with every input pushing for activity.
    repeat (2) @(negedge clk_i);
    chk("rst_desc_ready", {63'd0, desc_ready_o}, 64'd0);
    chk("rst_w_valid", {63'd0, w_valid_o}, 64'd0);
    chk("rst_buf_ready", {63'd0, buf_ready_o}, 64'd0);
    chk("rst_w_last", {63'd0, w_last_o}, 64'd0);
    chk("rst_done", {63'd0, burst_done_o}, 64'd0);
    chk("rst_strb", {56'd0, w_strb_o}, 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    desc_valid_i = 1'b0;
    @(negedge clk_i);
    chk("idle_desc_ready", {63'd0, desc_ready_o}, 64'd1);
    chk("idle_w_valid", {63'd0, w_valid_o}, 64'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // W stalled for three cycles on beat 1.
    @(posedge clk_i); #1;
    drive_desc(vecs[0]);
    w_ready_i = 1'b0;
    @(negedge clk_i);
    push_beats(vecs[0]);
    @(posedge clk_i); #1;
    desc_valid_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      chk("stall_valid", {63'd0, w_valid_o}, 64'd1);
      chk("stall_strb", {56'd0, w_strb_o}, 64'hF8);
      chk("stall_last", {63'd0, w_last_o}, 64'd0);
      chk("stall_buf_ready", {63'd0, buf_ready_o}, 64'd0);
      chk("stall_data", w_data_o, {4{exp_word}});
    end
    @(posedge clk_i); #1;
    w_ready_i = 1'b1;
    drain();

    // Two back-to-back two-beat descriptors: four beats in four cycles.
    va = '{off: 3'd4, tail: 3'd4, nb: 8'd1, single: 1'b0, s_first: 8'hF0, s_last: 8'h0F};
    vb = '{off: 3'd0, tail: 3'd2, nb: 8'd1, single: 1'b0, s_first: 8'hFF, s_last: 8'h03};
    @(posedge clk_i); #1;
    drive_desc(va);
    @(negedge clk_i);
    push_beats(va);
    @(posedge clk_i); #1;
    drive_desc(vb);
    @(negedge clk_i);
    chk("b2b_beat1_valid", {63'd0, w_valid_o}, 64'd1);
    chk("b2b_beat1_desc_ready", {63'd0, desc_ready_o}, 64'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("b2b_beat2_valid", {63'd0, w_valid_o}, 64'd1);
    chk("b2b_beat2_desc_ready", {63'd0, desc_ready_o}, 64'd1);
    push_beats(vb);
    @(posedge clk_i); #1;
    desc_valid_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_beat3_valid", {63'd0, w_valid_o}, 64'd1);
    @(negedge clk_i);
    chk("b2b_beat4_valid", {63'd0, w_valid_o}, 64'd1);
    chk("b2b_beat4_last", {63'd0, w_last_o}, 64'd1);
    drain();

    // Reset during beat 1 of a four-beat burst aborts it.
    va = '{off: 3'd0, tail: 3'd0, nb: 8'd3, single: 1'b0, s_first: 8'hFF, s_last: 8'hFF};
    @(posedge clk_i); #1;
    drive_desc(va);
    w_ready_i = 1'b0;
    @(posedge clk_i); #1;
    desc_valid_i = 1'b0;
    @(negedge clk_i);
    chk("pre_rst_valid", {63'd0, w_valid_o}, 64'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    w_ready_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_w_valid", {63'd0, w_valid_o}, 64'd0);
    chk("midrst_w_last", {63'd0, w_last_o}, 64'd0);
    chk("midrst_done", {63'd0, burst_done_o}, 64'd0);
    chk("midrst_buf_ready", {63'd0, buf_ready_o}, 64'd0);
    chk("midrst_desc_ready", {63'd0, desc_ready_o}, 64'd0);
    chk("midrst_strb", {56'd0, w_strb_o}, 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("postrst_desc_ready", {63'd0, desc_ready_o}, 64'd1);
    chk("postrst_w_valid", {63'd0, w_valid_o}, 64'd0);
    run_vec(vecs[4]);
    run_vec(vecs[0]);

    repeat (3) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
